arb_s00_axi_regs: RTL and testbench
===================================

ARB_S00_AXI_REGS -- requirements
Module: arb_s00_axi_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width (16 word slots).
REQ-003 SHALL have port S_AXI_ACLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have AW channel ports: S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-006 SHALL have W channel ports: S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-007 SHALL have B channel ports: S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 SHALL have AR channel ports: S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-009 SHALL have R channel ports: S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-010 SHALL have ports slv_reg0..slv_reg3  output  32 each  current register contents to arbiter core.

Function
REQ-011 SHALL act as AXI4-Lite responder; word index = ADDR[ADDR_WIDTH-1:2]; ADDR[1:0] ignored; indices 0..3 map to slv_reg0..3 (byte offsets 0x0,0x4,0x8,0xC).
REQ-012 SHALL accept AW and W independently, in either order or same cycle; each READY asserted while that channel is not yet captured and BVALID low; READY deasserted after its handshake.
REQ-013 SHALL commit the write in the cycle after both AW and W are captured, applying WSTRB per byte (bit n -> bits 8n+7:8n); unstrobed bytes unchanged.
REQ-014 SHALL assert BVALID in the same cycle as the commit and hold BVALID/BRESP stable until BREADY high; only one write outstanding; AWREADY/WREADY low until B handshake completes.
REQ-015 SHALL assert ARREADY while RVALID low and no read captured; on AR handshake, capture read data and assert RVALID next cycle.
REQ-016 SHALL hold RVALID, RDATA, RRESP stable until RREADY high; ARREADY low meanwhile; next AR accepted the cycle after R handshake.
REQ-017 SHALL give read/write paths no mutual priority; read capture and write commit to same register in one cycle returns pre-write value.
REQ-018 SHALL return BRESP/RRESP = 2'b00 (OKAY) for indices 0..3.
REQ-019 SHALL, for indices 4..15 without the REQ-024 macro: ignore writes, return RDATA 0, OKAY.
REQ-020 SHALL have worst-case latency: write 1 cycle from last of AW/W handshake to BVALID; read 1 cycle from AR handshake to RVALID.

Reset
REQ-021 SHALL, while S_AXI_ARESETN low, force asynchronously: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, slv_reg0..3 0, capture flags cleared.
REQ-022 SHALL abandon any in-flight transaction on reset mid-operation; no commit after reset deasserts.
REQ-023 SHALL assert AWREADY, WREADY, ARREADY in the first clock edge after reset release.

Configuration
REQ-024 SHALL, with macro ARB_S00_SLVERR_EN defined, return 2'b10 (SLVERR) on BRESP/RRESP for indices 4..15, writes discarded, RDATA 0; without it, REQ-019 applies.

Verification
REQ-025 SHALL cover: write 0x0101FFFF,0xABCD0001,0xDEAD0011,0xBEEF0011 to 0x0,0x4,0x8,0xC, each read back -> identical data, all RESP OKAY, slv_reg0..3 match.
REQ-026 SHALL cover: slv_reg1=0xABCD0001, write 0x12345678 WSTRB=4'b0101 -> read 0xAB340078.
REQ-027 SHALL cover: W presented 3 cycles before AW, BREADY held low 5 cycles -> single commit, BVALID held 5 cycles, AWREADY/WREADY low until B handshake.
REQ-028 SHALL cover: read 0x20 -> RDATA 0, RRESP 0x0 without macro, 0x2 with ARB_S00_SLVERR_EN; write 0x20 leaves slv_reg0..3 unchanged.
REQ-029 SHALL cover: reset asserted while BVALID high awaiting BREADY -> BVALID 0 and slv_reg0..3 0 immediately, READYs 1 after release.
REQ-030 SHALL cover: same-cycle read capture and write commit on 0x8 (old 0xDEAD0011, new 0x0) -> RDATA 0xDEAD0011, next read 0x0.

Source files
------------

// File: rtl/arb_s00_axi_regs.sv
// ============================================================================
// Module      : arb_s00_axi_regs
// Description : AXI4-Lite register slave that exposes four 32-bit control
//               registers (slv_reg0..3) to the arbiter core.
//               Byte offsets 0x0/0x4/0x8/0xC select slv_reg0..3. Word slots
//               4..15 are unmapped: writes to them are dropped and reads
//               return zero.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   S_AXI_ACLK            : single clock, rising edge
//   S_AXI_ARESETN         : asynchronous active-low reset
//   S_AXI_AW*             : write address channel (AWPROT ignored)
//   S_AXI_W*              : write data channel with byte strobes
//   S_AXI_B*              : write response channel
//   S_AXI_AR*             : read address channel (ARPROT ignored)
//   S_AXI_R*              : read data channel
//   slv_reg0..slv_reg3    : current register contents
// Configuration
//   ARB_S00_SLVERR_EN     : when defined, unmapped slots answer SLVERR
//                           instead of OKAY
// ============================================================================
`default_nettype none

module arb_s00_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    // write response channel
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    // register contents
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NUM_REGS = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef ARB_S00_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              r_awready, r_wready, r_arready;
    logic              r_bvalid,  r_rvalid;
    logic [1:0]        r_bresp,   r_rresp;
    logic [DW-1:0]     r_rdata;
    logic              r_aw_cap,  r_w_cap;
    logic [IDX_W-1:0]  r_awidx;
    logic [DW-1:0]     r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [DW-1:0]     r_regs [NUM_REGS];

    // next-state values
    logic              w_awready_nxt, w_wready_nxt, w_arready_nxt;
    logic              w_bvalid_nxt,  w_rvalid_nxt;
    logic [1:0]        w_bresp_nxt,   w_rresp_nxt;
    logic [DW-1:0]     w_rdata_nxt;
    logic              w_aw_cap_nxt,  w_w_cap_nxt;
    logic [IDX_W-1:0]  w_awidx_nxt;
    logic [DW-1:0]     w_wdata_nxt;
    logic [STRB_W-1:0] w_wstrb_nxt;
    logic [DW-1:0]     w_regs_nxt [NUM_REGS];

    // handshakes and the effective write/read operands
    logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [IDX_W-1:0]  w_aw_idx, w_ar_idx;
    logic [DW-1:0]     w_wdata_sel;
    logic [STRB_W-1:0] w_wstrb_sel;
    logic              w_aw_mapped, w_ar_mapped;

    // Protection bits and the byte lane within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_aw_hs = S_AXI_AWVALID && r_awready;
        w_w_hs  = S_AXI_WVALID  && r_wready;
        w_ar_hs = S_AXI_ARVALID && r_arready;

        // A channel handshaking this cycle supplies its operands directly,
        // so a commit can happen on the same edge as the final handshake.
        w_aw_idx    = w_aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : r_awidx;
        w_wdata_sel = w_w_hs  ? S_AXI_WDATA : r_wdata;
        w_wstrb_sel = w_w_hs  ? S_AXI_WSTRB : r_wstrb;
        w_ar_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

        w_aw_mapped = (w_aw_idx < IDX_W'(NUM_REGS));
        w_ar_mapped = (w_ar_idx < IDX_W'(NUM_REGS));

        w_commit = (r_aw_cap || w_aw_hs) && (r_w_cap || w_w_hs);

        // defaults: hold everything
        w_aw_cap_nxt = r_aw_cap;
        w_w_cap_nxt  = r_w_cap;
        w_awidx_nxt  = r_awidx;
        w_wdata_nxt  = r_wdata;
        w_wstrb_nxt  = r_wstrb;
        w_bvalid_nxt = r_bvalid;
        w_bresp_nxt  = r_bresp;
        w_rvalid_nxt = r_rvalid;
        w_rresp_nxt  = r_rresp;
        w_rdata_nxt  = r_rdata;
        w_regs_nxt   = r_regs;

        // ---------------- write path ----------------
        if (w_aw_hs) begin
            w_aw_cap_nxt = 1'b1;
            w_awidx_nxt  = w_aw_idx;
        end
        if (w_w_hs) begin
            w_w_cap_nxt = 1'b1;
            w_wdata_nxt = S_AXI_WDATA;
            w_wstrb_nxt = S_AXI_WSTRB;
        end
        if (r_bvalid && S_AXI_BREADY) begin
            w_bvalid_nxt = 1'b0;
        end
        if (w_commit) begin
            w_aw_cap_nxt = 1'b0;
            w_w_cap_nxt  = 1'b0;
            w_bvalid_nxt = 1'b1;
            w_bresp_nxt  = w_aw_mapped ? RESP_OKAY : RESP_UNMAPPED;
            if (w_aw_mapped) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (w_wstrb_sel[b]) begin
                        w_regs_nxt[w_aw_idx[1:0]][8*b +: 8] = w_wdata_sel[8*b +: 8];
                    end
                end
            end
        end

        // ---------------- read path ----------------
        // Read data comes from r_regs (pre-commit), so a read captured on
        // the commit edge returns the old contents.
        if (r_rvalid && S_AXI_RREADY) begin
            w_rvalid_nxt = 1'b0;
        end
        if (w_ar_hs) begin
            w_rvalid_nxt = 1'b1;
            w_rdata_nxt  = w_ar_mapped ? r_regs[w_ar_idx[1:0]] : '0;
            w_rresp_nxt  = w_ar_mapped ? RESP_OKAY : RESP_UNMAPPED;
        end

        // READYs are registered so they stay low through reset and rise
        // on the first edge after release.
        w_awready_nxt = !w_aw_cap_nxt && !w_bvalid_nxt;
        w_wready_nxt  = !w_w_cap_nxt  && !w_bvalid_nxt;
        w_arready_nxt = !w_rvalid_nxt;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_aw_cap  <= 1'b0;
            r_w_cap   <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_regs    <= '{default: '0};
        end else begin
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_arready <= w_arready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rdata   <= w_rdata_nxt;
            r_aw_cap  <= w_aw_cap_nxt;
            r_w_cap   <= w_w_cap_nxt;
            r_awidx   <= w_awidx_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_regs    <= w_regs_nxt;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    assign slv_reg0 = r_regs[0];
    assign slv_reg1 = r_regs[1];
    assign slv_reg2 = r_regs[2];
    assign slv_reg3 = r_regs[3];

endmodule

`default_nettype wire

// File: tb/tb_arb_s00_axi_regs.sv
// ============================================================================
// Module      : tb_arb_s00_axi_regs
// Description : Self-checking bench for arb_s00_axi_regs. A vector table
//               drives writes/reads; B and R responses are checked against
//               expectation queues filled when each transaction is issued.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_s00_axi_regs;

    localparam int DW = 32;
    localparam int AW = 6;
`ifdef ARB_S00_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif
    localparam logic [1:0] OK = 2'b00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awprot = 3'b000;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arprot = 3'b000;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [DW-1:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;

    always #5 clk = ~clk;

    arb_s00_axi_regs #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .slv_reg0      (slv_reg0),
        .slv_reg1      (slv_reg1),
        .slv_reg2      (slv_reg2),
        .slv_reg3      (slv_reg3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t bq[$];
    rsp_t rq[$];

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
        logic [31:0]   exp_data;
        logic [1:0]    exp_resp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- response scoreboards ----------------
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (bq.size() == 0) begin
                check("b_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = bq.pop_front();
                check("bresp", {30'b0, bresp}, {30'b0, e.resp});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = rq.pop_front();
                check("rdata", rdata, e.data);
                check("rresp", {30'b0, rresp}, {30'b0, e.resp});
            end
        end
    end

    // ---------------- transaction tasks ----------------
    // W is presented w_lead cycles before AW; BREADY stays low for b_hold
    // (>=1) observed cycles of BVALID.
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er, input int w_lead, input int b_hold);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        int held, bad_rdy;
        bq.push_back({32'h0, er});
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (w_lead == 0);
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
            if (!aw_done && !awvalid && cyc >= w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("write_accept", {30'b0, aw_done, w_done}, 32'h3);
        @(negedge clk);
        check("bvalid_latency", {31'b0, bvalid}, 32'd1);
        held = 0; bad_rdy = 0;
        for (int i = 0; i < b_hold; i++) begin
            if (bvalid) held++;
            if (awready || wready) bad_rdy++;
            @(posedge clk); #1;
            if (i < b_hold - 1) @(negedge clk);
        end
        check("bvalid_held", held, b_hold);
        check("ready_low_until_b", bad_rdy, 0);
        bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("bvalid_drop", {31'b0, bvalid}, 32'd0);
        check("wready_after_b", {30'b0, awready, wready}, 32'h3);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [31:0] ed, input logic [1:0] er,
                           input int r_hold);
        int cyc, bad;
        bit got;
        logic [31:0] snap;
        rq.push_back({ed, er});
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            got = arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 1'b0;
        check("ar_accept", {31'b0, got}, 32'd1);
        @(negedge clk);
        check("rvalid_latency", {31'b0, rvalid}, 32'd1);
        snap = rdata; bad = 0;
        for (int i = 0; i < r_hold; i++) begin
            if (!rvalid || rdata !== snap || arready) bad++;
            @(posedge clk); #1;
            if (i < r_hold - 1) @(negedge clk);
        end
        check("r_stable", bad, 0);
        rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        check("arready_after_r", {30'b0, arready, rvalid}, 32'h2);
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        check({tag, "_slv_reg0"}, slv_reg0, e0);
        check({tag, "_slv_reg1"}, slv_reg1, e1);
        check({tag, "_slv_reg2"}, slv_reg2, e2);
        check({tag, "_slv_reg3"}, slv_reg3, e3);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b1, 6'h00, 32'h0101FFFF, 4'hF, 32'h0,        OK};
        vecs[1]  = '{1'b1, 6'h04, 32'hABCD0001, 4'hF, 32'h0,        OK};
        vecs[2]  = '{1'b1, 6'h08, 32'hDEAD0011, 4'hF, 32'h0,        OK};
        vecs[3]  = '{1'b1, 6'h0C, 32'hBEEF0011, 4'hF, 32'h0,        OK};
        vecs[4]  = '{1'b0, 6'h00, 32'h0,        4'h0, 32'h0101FFFF, OK};
        vecs[5]  = '{1'b0, 6'h04, 32'h0,        4'h0, 32'hABCD0001, OK};
        vecs[6]  = '{1'b0, 6'h08, 32'h0,        4'h0, 32'hDEAD0011, OK};
        vecs[7]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 32'hBEEF0011, OK};
        vecs[8]  = '{1'b1, 6'h04, 32'h12345678, 4'h5, 32'h0,        OK};
        vecs[9]  = '{1'b0, 6'h04, 32'h0,        4'h0, 32'hAB340078, OK};
        vecs[10] = '{1'b1, 6'h20, 32'hFFFFFFFF, 4'hF, 32'h0,        OOR};
        vecs[11] = '{1'b0, 6'h20, 32'h0,        4'h0, 32'h0,        OOR};
        vecs[12] = '{1'b0, 6'h03, 32'h0,        4'h0, 32'h0101FFFF, OK};
        vecs[13] = '{1'b0, 6'h3C, 32'h0,        4'h0, 32'h0,        OOR};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_readies", {29'b0, awready, wready, arready}, 32'h0);
        check("rst_valids", {30'b0, bvalid, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check_regs("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("readies_after_release", {29'b0, awready, wready, arready}, 32'h7);

        // table-driven transactions
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, 0, 1);
            else
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, 1 + (i % 3));
        end
        check_regs("table", 32'h0101FFFF, 32'hAB340078, 32'hDEAD0011, 32'hBEEF0011);

        // W three cycles ahead of AW, BREADY held low five cycles
        do_write(6'h0C, 32'h11112222, 4'hF, OK, 3, 5);
        check_regs("wlead", 32'h0101FFFF, 32'hAB340078, 32'hDEAD0011, 32'h11112222);
        do_read(6'h0C, 32'h11112222, OK, 1);

        // read capture on the same edge as a write commit to 0x8
        bq.push_back({32'h0, OK});
        rq.push_back({32'hDEAD0011, OK});
        @(posedge clk); #1;
        awaddr = 6'h08; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h08; arvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        check("same_edge_readies", {29'b0, awready, wready, arready}, 32'h7);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        check("same_edge_valids", {30'b0, bvalid, rvalid}, 32'h3);
        check("same_edge_slv_reg2", slv_reg2, 32'h0);
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        do_read(6'h08, 32'h0, OK, 1);

        // reset while BVALID waits for BREADY
        @(posedge clk); #1;
        awaddr = 6'h04; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("b_before_reset", {31'b0, bvalid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_bvalid", {31'b0, bvalid}, 32'd0);
        check_regs("reset_mid", 32'h0, 32'h0, 32'h0, 32'h0);
        check("reset_readies", {29'b0, awready, wready, arready}, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("readies_after_rerelease", {29'b0, awready, wready, arready}, 32'h7);
        repeat (3) @(negedge clk);
        check("no_commit_after_reset", {31'b0, bvalid}, 32'd0);
        check_regs("post_reset", 32'h0, 32'h0, 32'h0, 32'h0);

        check("bq_drained", bq.size(), 32'd0);
        check("rq_drained", rq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
